// File: rtl/encoder_frontend.sv
// N-channel quadrature encoder front end: sync, glitch filter, x4 decode into wrapping
// positions, windowed saturating velocity, sticky illegal-step flags and a selected control state.
module encoder_frontend #(
    parameter int NUM_CH     = 2,
    parameter int POS_W      = 32,
    parameter int VEL_W      = 16,
    parameter int FILT_LEN   = 4,
    parameter int VEL_WINDOW = 16000
) (
    input  logic                      CLK,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic [NUM_CH-1:0]         set_origin,
    input  logic [NUM_CH-1:0]         err_clear,
    input  logic [7:0]                sel,
    output logic [NUM_CH*POS_W-1:0]   position,
    output logic [NUM_CH*VEL_W-1:0]   velocity,
    output logic                      vel_valid,
    output logic [NUM_CH-1:0]         direction,
    output logic [NUM_CH-1:0]         error,
    output logic [POS_W-1:0]          state
);

    localparam int NB        = 2 * NUM_CH;
    localparam int FC_W      = $clog2(FILT_LEN + 1);
    localparam int PRIME_LEN = FILT_LEN + 2;
    localparam int PR_W      = $clog2(PRIME_LEN + 1);
    localparam int WIN_W     = $clog2(VEL_WINDOW + 1);

    // Bit k < NUM_CH is A of channel k, bit NUM_CH+k is B of channel k.
    logic [NB-1:0]     sync1_q, sync2_q, filt_q, prev_q;
    logic [FC_W-1:0]   fcnt_q [NB];
    logic [PR_W-1:0]   prime_q;
    logic [WIN_W-1:0]  win_q;
    logic [POS_W-1:0]  pos_q [NUM_CH];
    logic [VEL_W-1:0]  acc_q [NUM_CH];
    logic [VEL_W-1:0]  vel_q [NUM_CH];
    logic [NUM_CH-1:0] dir_q, err_q;
    logic              vel_valid_q;
    logic [POS_W-1:0]  state_q;

    logic              priming, win_last;
    logic [NUM_CH-1:0] inc_d, dec_d, bad_d;
    logic [VEL_W-1:0]  acc_d [NUM_CH];
    logic [POS_W-1:0]  state_d;

    function automatic logic [1:0] pick_ab(input logic [NB-1:0] v, input int c);
        return {v[c], v[NUM_CH+c]};
    endfunction

    // Forward order in {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [VEL_W-1:0] sat_step(input logic [VEL_W-1:0] a,
                                                  input logic up, input logic dn);
        logic [VEL_W:0] s;
        s = {a[VEL_W-1], a};
        if (up)      s = s + {{VEL_W{1'b0}}, 1'b1};
        else if (dn) s = s - {{VEL_W{1'b0}}, 1'b1};
        if (s[VEL_W] != s[VEL_W-1])
            return s[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
        return s[VEL_W-1:0];
    endfunction

    assign priming  = (prime_q < PR_W'(PRIME_LEN));
    assign win_last = (win_q == WIN_W'(VEL_WINDOW - 1));

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            inc_d[c] = !priming && (fwd_next(pick_ab(prev_q, c)) == pick_ab(filt_q, c));
            dec_d[c] = !priming && (fwd_next(pick_ab(filt_q, c)) == pick_ab(prev_q, c));
            bad_d[c] = !priming && ((pick_ab(prev_q, c) ^ pick_ab(filt_q, c)) == 2'b11);
            acc_d[c] = sat_step(acc_q[c], inc_d[c], dec_d[c]);
        end
    end

    always_comb begin
        state_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == 8'(c)) state_d = pos_q[c];
        end
        if (sel == 8'(NUM_CH)) state_d = pos_q[1] - pos_q[0];
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            prev_q      <= '0;
            prime_q     <= '0;
            win_q       <= '0;
            vel_valid_q <= 1'b0;
            dir_q       <= '0;
            err_q       <= '0;
            state_q     <= '0;
            for (int k = 0; k < NB; k++) fcnt_q[k] <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pos_q[c] <= '0;
                acc_q[c] <= '0;
                vel_q[c] <= '0;
            end
        end else begin
            sync1_q <= {enc_b, enc_a};
            sync2_q <= sync1_q;
            // While priming, track the synced levels directly so the idle level never counts.
            if (priming) begin
                prime_q <= prime_q + 1'b1;
                filt_q  <= sync2_q;
                prev_q  <= sync2_q;
                for (int k = 0; k < NB; k++) fcnt_q[k] <= '0;
            end else begin
                prev_q <= filt_q;
                for (int k = 0; k < NB; k++) begin
                    if (sync2_q[k] != filt_q[k]) begin
                        if (fcnt_q[k] == FC_W'(FILT_LEN - 1)) begin
                            filt_q[k] <= sync2_q[k];
                            fcnt_q[k] <= '0;
                        end else begin
                            fcnt_q[k] <= fcnt_q[k] + 1'b1;
                        end
                    end else begin
                        fcnt_q[k] <= '0;
                    end
                end
            end

            win_q       <= win_last ? '0 : win_q + 1'b1;
            vel_valid_q <= win_last;

            for (int c = 0; c < NUM_CH; c++) begin
                if (set_origin[c])  pos_q[c] <= '0;
                else if (inc_d[c])  pos_q[c] <= pos_q[c] + 1'b1;
                else if (dec_d[c])  pos_q[c] <= pos_q[c] - 1'b1;
                if (inc_d[c] || dec_d[c]) dir_q[c] <= dec_d[c];
                if (bad_d[c])           err_q[c] <= 1'b1;
                else if (err_clear[c])  err_q[c] <= 1'b0;
                if (win_last) begin
                    vel_q[c] <= acc_d[c];
                    acc_q[c] <= '0;
                end else begin
                    acc_q[c] <= acc_d[c];
                end
            end

            state_q <= state_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            position[c*POS_W +: POS_W] = pos_q[c];
            velocity[c*VEL_W +: VEL_W] = vel_q[c];
        end
    end

    assign vel_valid = vel_valid_q;
    assign direction = dir_q;
    assign error     = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_encoder_frontend.sv
// Directed and randomized bench for encoder_frontend against a step-level reference model
// that tracks positions, per-window counts and flags from the driven quadrature sequence.
module tb_encoder_frontend;

    localparam int NUM_CH     = 2;
    localparam int POS_W      = 32;
    localparam int VEL_W      = 16;
    localparam int FILT_LEN   = 4;
    localparam int VEL_WINDOW = 100;
    localparam int LAT        = FILT_LEN + 2;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       enc_a, enc_b, set_origin, err_clear;
    logic [7:0]              sel;
    logic [NUM_CH*POS_W-1:0] position;
    logic [NUM_CH*VEL_W-1:0] velocity;
    logic                    vel_valid;
    logic [NUM_CH-1:0]       direction, error;
    logic [POS_W-1:0]        state;

    encoder_frontend #(
        .NUM_CH(NUM_CH), .POS_W(POS_W), .VEL_W(VEL_W),
        .FILT_LEN(FILT_LEN), .VEL_WINDOW(VEL_WINDOW)
    ) dut (
        .CLK(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .set_origin(set_origin), .err_clear(err_clear), .sel(sel),
        .position(position), .velocity(velocity), .vel_valid(vel_valid),
        .direction(direction), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;
    int edge_cnt = 0;
    bit mon_en = 1'b0;
    bit exp_valid;

    logic [1:0]  fwd_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0]  lvl     [NUM_CH];
    logic [31:0] pos_exp [NUM_CH];
    logic        dir_exp [NUM_CH];
    logic        err_exp [NUM_CH];
    int          win_sum [NUM_CH][0:255];

    always @(posedge clk) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] clamp_vel(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic int seq_idx(input logic [1:0] v);
        for (int i = 0; i < 4; i++) if (fwd_seq[i] == v) return i;
        return 0;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_lvl(input int ch, input logic [1:0] v);
        enc_a[ch] = v[1];
        enc_b[ch] = v[0];
        lvl[ch]   = v;
    endtask

    // One legal x4 step; the count lands LAT edges after the first sampling edge.
    task automatic step(input int ch, input bit down);
        int d;
        drive_lvl(ch, fwd_seq[(seq_idx(lvl[ch]) + (down ? 3 : 1)) % 4]);
        d = edge_cnt + 1 + LAT;
        win_sum[ch][(d - 1) / VEL_WINDOW] += down ? -1 : 1;
        pos_exp[ch] = down ? pos_exp[ch] - 32'd1 : pos_exp[ch] + 32'd1;
        dir_exp[ch] = down;
    endtask

    task automatic check_ch(input int ch, input string tag);
        check({tag, "_pos"}, position[ch*POS_W +: POS_W], pos_exp[ch]);
        check({tag, "_dir"}, 32'(direction[ch]), 32'(dir_exp[ch]));
        check({tag, "_err"}, 32'(error[ch]), 32'(err_exp[ch]));
    endtask

    task automatic check_sel(input logic [7:0] s);
        logic [31:0] e;
        sel = s;
        wait_cyc(1);
        if (s < 8'(NUM_CH))       e = pos_exp[s[0]];
        else if (s == 8'(NUM_CH)) e = pos_exp[1] - pos_exp[0];
        else                      e = '0;
        check("state_sel", state, e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_valid = (edge_cnt > 0) && (edge_cnt % VEL_WINDOW == 0);
            check("vel_valid", 32'(vel_valid), 32'(exp_valid));
            if (exp_valid) begin
                for (int c = 0; c < NUM_CH; c++)
                    check("velocity", 32'(velocity[c*VEL_W +: VEL_W]),
                          32'(clamp_vel(win_sum[c][edge_cnt / VEL_WINDOW - 1])));
            end
        end
    end

    initial begin
        int n;
        bit hit;
        reset_n    = 1'b0;
        set_origin = '0;
        err_clear  = '0;
        sel        = 8'd0;
        enc_a      = '0;
        enc_b      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drive_lvl(c, 2'b11);
            pos_exp[c] = '0;
            dir_exp[c] = 1'b0;
            err_exp[c] = 1'b0;
            for (int w = 0; w < 256; w++) win_sum[c][w] = 0;
        end
        wait_cyc(3);
        check("rst_position", position[31:0] | position[63:32], 32'd0);
        check("rst_velocity", 32'(velocity), 32'd0);
        check("rst_flags", {28'd0, direction, error}, 32'd0);
        check("rst_state", state, 32'd0);

        // Release with A=B=1 held: no count and no error through priming.
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_cyc(1);
            mon_en = 1'b1;
            check("prime_pos", position[31:0] | position[63:32], 32'd0);
            check("prime_err", 32'(error), 32'd0);
        end

        // Forward steps on ch0 with exact latency on the first one.
        step(0, 1'b0);
        wait_cyc(LAT);
        check("lat_before", position[31:0], 32'd0);
        wait_cyc(1);
        check("lat_after", position[31:0], 32'd1);
        wait_cyc(3);
        for (int i = 0; i < 7; i++) begin
            step(0, 1'b0);
            wait_cyc(10);
        end
        check("fwd8_pos", position[31:0], 32'd8);
        check_ch(0, "fwd8");

        // Short glitch on ch1 is rejected.
        enc_a[1] = ~lvl[1][1];
        wait_cyc(3);
        enc_a[1] = lvl[1][1];
        wait_cyc(10);
        check_ch(1, "glitch");

        // 11 -> 01 -> 00, then illegal jump to 11.
        step(1, 1'b0); wait_cyc(10);
        step(1, 1'b0); wait_cyc(10);
        drive_lvl(1, 2'b11);
        err_exp[1] = 1'b1;
        wait_cyc(10);
        check_ch(1, "illegal");
        err_clear[1] = 1'b1; wait_cyc(1); err_clear[1] = 1'b0;
        err_exp[1] = 1'b0;
        wait_cyc(1);
        check_ch(1, "errclr");

        // Illegal jump with err_clear on the same edge: set wins.
        drive_lvl(1, 2'b00);
        wait_cyc(LAT);
        err_clear[1] = 1'b1; wait_cyc(1); err_clear[1] = 1'b0;
        err_exp[1] = 1'b1;
        check_ch(1, "set_vs_clr");
        err_clear[1] = 1'b1; wait_cyc(1); err_clear[1] = 1'b0;
        err_exp[1] = 1'b0;
        wait_cyc(1);
        check_ch(1, "errclr2");

        // Origin, reverse wrap to all ones, origin coinciding with a count.
        set_origin[0] = 1'b1; wait_cyc(1); set_origin[0] = 1'b0;
        pos_exp[0] = '0;
        check_ch(0, "origin");
        step(0, 1'b1); wait_cyc(10);
        check("wrap_neg1", position[31:0], 32'hFFFF_FFFF);
        check_ch(0, "rev");
        step(0, 1'b0);
        wait_cyc(LAT);
        set_origin[0] = 1'b1; wait_cyc(1); set_origin[0] = 1'b0;
        pos_exp[0] = '0;
        wait_cyc(4);
        check_ch(0, "origin_vs_step");

        // 25 forward steps fitted inside one velocity window, then a quiet window.
        n = 0;
        while ((edge_cnt % VEL_WINDOW) != VEL_WINDOW - 4 && n < 300) begin
            wait_cyc(1);
            n++;
        end
        check("align_timeout", 32'(n < 300), 32'd1);
        for (int i = 0; i < 25; i++) begin
            step(0, 1'b0);
            wait_cyc(4);
        end
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (vel_valid) hit = 1'b1;
            else wait_cyc(1);
        end
        check("vel25_seen", 32'(hit), 32'd1);
        check("vel25", 32'(velocity[15:0]), 32'd25);
        wait_cyc(1);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (vel_valid) hit = 1'b1;
            else wait_cyc(1);
        end
        check("vel0_seen", 32'(hit), 32'd1);
        check("vel_quiet", 32'(velocity[15:0]), 32'd0);

        // Build position1=500, position0=200 with simultaneous steps on both channels.
        set_origin = '1; wait_cyc(1); set_origin = '0;
        pos_exp[0] = '0;
        pos_exp[1] = '0;
        for (int i = 0; i < 200; i++) begin
            step(0, 1'b0);
            step(1, 1'b0);
            wait_cyc(4);
        end
        for (int i = 0; i < 300; i++) begin
            step(1, 1'b0);
            wait_cyc(4);
        end
        wait_cyc(10);
        check("pos1_500", position[63:32], 32'd500);
        check("pos0_200", position[31:0], 32'd200);
        sel = 8'd2;
        wait_cyc(1);
        check("state_disp", state, 32'd300);
        sel = 8'd0;
        wait_cyc(1);
        check("state_pos0", state, 32'd200);
        sel = 8'd7;
        wait_cyc(1);
        check("state_other", state, 32'd0);
        check_sel(8'd1);

        // Randomized steps and glitches on both channels.
        for (int it = 0; it < 150; it++) begin
            int ch;
            ch = int'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 9) < 2) begin
                if ($urandom_range(0, 1) == 1) enc_a[ch] = ~lvl[ch][1];
                else                          enc_b[ch] = ~lvl[ch][0];
                wait_cyc(int'($urandom_range(1, FILT_LEN - 1)));
                drive_lvl(ch, lvl[ch]);
                wait_cyc(5);
            end else begin
                step(ch, 1'($urandom_range(0, 1)));
                wait_cyc(int'($urandom_range(4, 9)));
            end
            if (it % 15 == 14) begin
                wait_cyc(10);
                check_ch(0, "rnd_ch0");
                check_ch(1, "rnd_ch1");
                check_sel(8'($urandom_range(0, 7)));
                check_sel(8'd2);
            end
        end
        wait_cyc(10);
        check_ch(0, "final_ch0");
        check_ch(1, "final_ch1");
        mon_en = 1'b0;
        wait_cyc(1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
